// File: rtl/cpu_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer.
package cpu_pkg;

  localparam int STATE_W     = 3;
  localparam int INSTR_BYTES = 4;

  localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] S_MEM    = 3'd3;
  localparam logic [STATE_W-1:0] S_WB     = 3'd4;
  localparam logic [STATE_W-1:0] S_HALT   = 3'd5;
  localparam logic [STATE_W-1:0] S_FAULT  = 3'd6;

  function automatic logic [63:0] seq_pc(input logic [63:0] pc_cur);
    return pc_cur + 64'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Memory wait watchdog: flags a request that has gone unacknowledged for TIMEOUT cycles.
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

  // Down-counter of wait cycles left; terminal count is reached on the last allowed cycle.
  logic [W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (!reset) begin
      remaining <= LOAD;
    end else if (!req || ack) begin
      remaining <= LOAD;
    end else if (remaining != '0) begin
      remaining <= remaining - 1'b1;
    end
  end

  // An ack on the final cycle wins over expiry.
  assign expired = req && !ack && (remaining == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle LEGv8 control sequencer: owns PC, retired count and halt/fault state.
//
// state  | meaning
// FETCH  | instruction fetch request outstanding
// DECODE | instruction register valid, decode/halt check
// EXEC   | ALU cycle, select memory phase or writeback
// MEM    | data load/store request outstanding
// WB     | register/flag writeback, PC update, retire
// HALT   | stopped by HLT, sticky until reset
// FAULT  | stopped by timeout or misaligned branch, sticky until reset
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [63:0] INITPC  = 64'h0,
  parameter int          TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_ack,
  input  logic         is_load,
  input  logic         is_store,
  input  logic         is_halt,
  input  logic         RegWrite,
  input  logic         FlagWrite,
  input  logic         branch_taken,
  input  logic [63:0]  pc_target,
  output logic [63:0]  pc,
  output logic         mem_req,
  output logic         mem_sel,
  output logic         mem_we,
  output logic         ir_load,
  output logic         mdr_load,
  output logic         reg_write_en,
  output logic         flag_write_en,
  output logic         halted,
  output logic         fault,
  output logic [63:0]  instret,
  output logic [2:0]   state
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [63:0]        instret_q, instret_d;
  logic               expired;
  logic               misaligned;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .req     (mem_req),
    .ack     (mem_ack),
    .expired (expired)
  );

  assign misaligned = branch_taken && (pc_target[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack)      state_d = S_DECODE;
        else if (expired) state_d = S_FAULT;
      end
      S_DECODE: state_d = is_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ack)      state_d = S_WB;
        else if (expired) state_d = S_FAULT;
      end
      S_WB: begin
        if (misaligned) begin
          state_d = S_FAULT;
        end else begin
          pc_d      = branch_taken ? pc_target : seq_pc(pc_q);
          instret_d = instret_q + 64'd1;
          state_d   = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= INITPC;
      instret_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are forced low while reset is asserted so nothing fires mid-reset.
  always_comb begin
    mem_req       = 1'b0;
    mem_sel       = 1'b0;
    mem_we        = 1'b0;
    ir_load       = 1'b0;
    mdr_load      = 1'b0;
    reg_write_en  = 1'b0;
    flag_write_en = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ack;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_sel  = 1'b1;
          mem_we   = is_store;
          mdr_load = mem_ack && is_load;
        end
        S_WB: begin
          reg_write_en  = RegWrite && !is_store;
          flag_write_en = FlagWrite;
        end
        S_HALT: halted = 1'b1;
        S_FAULT, 3'd7: begin
          halted = 1'b1;
          fault  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc      = pc_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset, ALU/load/store/branch flows, timeout and halt.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_ack = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        is_halt = 1'b0;
  logic        RegWrite = 1'b0;
  logic        FlagWrite = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] pc_target = 64'h0;
  logic [63:0] pc;
  logic        mem_req, mem_sel, mem_we, ir_load, mdr_load;
  logic        reg_write_en, flag_write_en, halted, fault;
  logic [63:0] instret;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  cpu_sequencer #(.INITPC(64'h0), .TIMEOUT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_ack       (mem_ack),
    .is_load       (is_load),
    .is_store      (is_store),
    .is_halt       (is_halt),
    .RegWrite      (RegWrite),
    .FlagWrite     (FlagWrite),
    .branch_taken  (branch_taken),
    .pc_target     (pc_target),
    .pc            (pc),
    .mem_req       (mem_req),
    .mem_sel       (mem_sel),
    .mem_we        (mem_we),
    .ir_load       (ir_load),
    .mdr_load      (mdr_load),
    .reg_write_en  (reg_write_en),
    .flag_write_en (flag_write_en),
    .halted        (halted),
    .fault         (fault),
    .instret       (instret),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    mem_ack = 0; is_load = 0; is_store = 0; is_halt = 0;
    RegWrite = 0; FlagWrite = 0; branch_taken = 0; pc_target = 64'h0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    tick();
    tick();
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req_during: got %0b want 0", mem_req); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted_during: got %0b want 0", halted); end
    reset = 1;
    #1;
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %0h want 0", pc); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_halt_fault: got %0b%0b want 00", halted, fault); end
    checks++; if (mem_req !== 1'b1 || mem_sel !== 1'b0) begin errors++; $display("FAIL reset_fetch_req: req=%0b sel=%0b want 1 0", mem_req, mem_sel); end
  endtask

  // ALU op, ack in the second FETCH cycle; WB is the fifth cycle counted from FETCH entry.
  task automatic test_alu();
    logic [2:0] exp_st [5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4};
    int rw_cnt = 0;
    int rw_cyc = -1;
    int ir_cnt = 0;
    clear_inputs();
    RegWrite = 1;
    for (int c = 0; c < 5; c++) begin
      mem_ack = (c == 1);
      #1;
      checks++; if (state !== exp_st[c]) begin errors++; $display("FAIL alu_state_c%0d: got %0d want %0d", c, state, exp_st[c]); end
      if (reg_write_en === 1'b1) begin rw_cnt++; rw_cyc = c; end
      if (ir_load === 1'b1) ir_cnt++;
      tick();
    end
    mem_ack = 0;
    #1;
    checks++; if (rw_cnt != 1 || rw_cyc != 4) begin errors++; $display("FAIL alu_reg_write: got %0d pulses at cycle %0d want 1 at 4", rw_cnt, rw_cyc); end
    checks++; if (ir_cnt != 1) begin errors++; $display("FAIL alu_ir_load: got %0d pulses want 1", ir_cnt); end
    checks++; if (pc !== 64'h4) begin errors++; $display("FAIL alu_pc: got %0h want 4", pc); end
    checks++; if (instret !== 64'd1) begin errors++; $display("FAIL alu_instret: got %0d want 1", instret); end
    checks++; if (mem_req !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL alu_next_fetch: req=%0b state=%0d want 1 0", mem_req, state); end
  endtask

  // LDUR: fetch ack immediately, data ack on the third MEM cycle.
  task automatic test_load();
    logic [2:0] exp_st [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    clear_inputs();
    is_load = 1; RegWrite = 1;
    for (int c = 0; c < 7; c++) begin
      mem_ack = (c == 0) || (c == 5);
      #1;
      checks++; if (state !== exp_st[c]) begin errors++; $display("FAIL load_state_c%0d: got %0d want %0d", c, state, exp_st[c]); end
      if (c >= 3 && c <= 5) begin
        checks++; if (mem_req !== 1'b1 || mem_sel !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL load_mem_c%0d: req=%0b sel=%0b we=%0b want 1 1 0", c, mem_req, mem_sel, mem_we); end
      end
      checks++; if (mdr_load !== (c == 5)) begin errors++; $display("FAIL load_mdr_c%0d: got %0b want %0b", c, mdr_load, (c == 5)); end
      checks++; if (reg_write_en !== (c == 6)) begin errors++; $display("FAIL load_rw_c%0d: got %0b want %0b", c, reg_write_en, (c == 6)); end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (pc !== 64'h8 || instret !== 64'd2) begin errors++; $display("FAIL load_retire: pc=%0h instret=%0d want 8 2", pc, instret); end
  endtask

  // STUR with RegWrite set: write enable to the register file must stay low.
  task automatic test_store();
    int rw_cnt = 0;
    clear_inputs();
    is_store = 1; RegWrite = 1;
    for (int c = 0; c < 5; c++) begin
      mem_ack = (c == 0) || (c == 3);
      #1;
      if (reg_write_en !== 1'b0) rw_cnt++;
      if (c == 3) begin
        checks++; if (state !== 3'd3 || mem_we !== 1'b1 || mem_sel !== 1'b1) begin errors++; $display("FAIL store_mem: state=%0d we=%0b sel=%0b want 3 1 1", state, mem_we, mem_sel); end
        checks++; if (mdr_load !== 1'b0) begin errors++; $display("FAIL store_mdr: got %0b want 0", mdr_load); end
      end
      if (c == 4) begin
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL store_wb_state: got %0d want 4", state); end
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (rw_cnt != 0) begin errors++; $display("FAIL store_reg_write: got %0d high cycles want 0", rw_cnt); end
    checks++; if (pc !== 64'hC || instret !== 64'd3) begin errors++; $display("FAIL store_retire: pc=%0h instret=%0d want c 3", pc, instret); end
  endtask

  task automatic test_branch();
    int req_cnt = 0;
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      mem_ack = (c == 0);
      branch_taken = (c == 3);
      pc_target = 64'h40;
      #1;
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (pc !== 64'h40 || state !== 3'd0 || instret !== 64'd4) begin errors++; $display("FAIL branch_taken: pc=%0h state=%0d instret=%0d want 40 0 4", pc, state, instret); end
    for (int c = 0; c < 4; c++) begin
      mem_ack = (c == 0);
      branch_taken = (c == 3);
      FlagWrite = (c == 3);
      RegWrite = (c == 3);
      pc_target = 64'h42;
      #1;
      if (c == 3) begin
        checks++; if (flag_write_en !== 1'b1 || reg_write_en !== 1'b1) begin errors++; $display("FAIL branch_mis_strobes: flag=%0b reg=%0b want 1 1", flag_write_en, reg_write_en); end
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (state !== 3'd6 || fault !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL branch_mis_fault: state=%0d fault=%0b halted=%0b want 6 1 1", state, fault, halted); end
    checks++; if (pc !== 64'h40 || instret !== 64'd4) begin errors++; $display("FAIL branch_mis_pc: pc=%0h instret=%0d want 40 4", pc, instret); end
    for (int c = 0; c < 6; c++) begin
      mem_ack = c[0];
      #1;
      if (mem_req !== 1'b0) req_cnt++;
      tick();
    end
    mem_ack = 0;
    checks++; if (req_cnt != 0 || state !== 3'd6) begin errors++; $display("FAIL branch_fault_sticky: req cycles=%0d state=%0d want 0 6", req_cnt, state); end
  endtask

  task automatic test_timeout_fault();
    int bad = 0;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      mem_ack = 0;
      #1;
      if (state !== 3'd0 || mem_req !== 1'b1) bad++;
      tick();
    end
    #1;
    checks++; if (bad != 0) begin errors++; $display("FAIL timeout_waiting: got %0d bad cycles want 0", bad); end
    checks++; if (state !== 3'd6 || fault !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_fault: state=%0d fault=%0b req=%0b want 6 1 0", state, fault, mem_req); end
  endtask

  task automatic test_timeout_ack_halt();
    int bad_req = 0;
    int bad_halt = 0;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      mem_ack = (c == 0);
      #1;
      tick();
    end
    mem_ack = 0;
    #1;
    checks++; if (pc !== 64'h4 || state !== 3'd0) begin errors++; $display("FAIL ack8_pre_pc: pc=%0h state=%0d want 4 0", pc, state); end
    for (int c = 0; c < 8; c++) begin
      mem_ack = (c == 7);
      #1;
      if (c == 7) begin
        checks++; if (ir_load !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL ack8_ir_load: ir=%0b state=%0d want 1 0", ir_load, state); end
      end
      tick();
    end
    mem_ack = 0;
    #1;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL ack8_decode: got %0d want 1", state); end
    is_halt = 1;
    #1;
    tick();
    is_halt = 0;
    #1;
    checks++; if (state !== 3'd5 || halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL halt_state: state=%0d halted=%0b fault=%0b want 5 1 0", state, halted, fault); end
    for (int c = 0; c < 100; c++) begin
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      if (mem_req !== 1'b0) bad_req++;
      if (halted !== 1'b1 || state !== 3'd5) bad_halt++;
      tick();
    end
    mem_ack = 0;
    #1;
    checks++; if (bad_req != 0) begin errors++; $display("FAIL halt_mem_req: got %0d high cycles want 0", bad_req); end
    checks++; if (bad_halt != 0) begin errors++; $display("FAIL halt_sticky: got %0d bad cycles want 0", bad_halt); end
    checks++; if (pc !== 64'h4 || instret !== 64'd1) begin errors++; $display("FAIL halt_frozen: pc=%0h instret=%0d want 4 1", pc, instret); end
  endtask

  task automatic test_restart();
    reset = 0;
    #1;
    checks++; if (halted !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL restart_during: halted=%0b req=%0b want 0 0", halted, mem_req); end
    tick();
    reset = 1;
    #1;
    checks++; if (state !== 3'd0 || pc !== 64'h0 || instret !== 64'd0) begin errors++; $display("FAIL restart_state: state=%0d pc=%0h instret=%0d want 0 0 0", state, pc, instret); end
    checks++; if (mem_req !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL restart_fetch: req=%0b halted=%0b want 1 0", mem_req, halted); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_timeout_fault();
    test_timeout_ack_halt();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
